mac_row_issuer: RTL and testbench
=================================

Name: mac_row_issuer

Overview:
- Transmit side of the mac input interface (wr/row/v0/v1/eof).
- Takes a ready/valid stream of matrix nonzeros paired with gathered vector values, plus row-end and matrix-end flags.
- Assigns each nonzero a wrapping intermediator row tag and issues one registered mac write per accepted nonzero.
- Limits open rows to the intermediator depth with a credit counter, which mac result pushes replenish.
- Generates the eof flush and reports completion once every issued row has retired.

Parameters:
- INTERMEDIATOR_DEPTH, 1024: number of row slots in the downstream intermediator; maximum rows in flight.
- LOG2_INTERMEDIATOR_DEPTH, log2(INTERMEDIATOR_DEPTH-1): row tag width, from the shared common.vh log2 function.

Ports:
- clk  input  1  clock.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle pulse that begins a matrix pass; only honoured in IDLE.
- in_valid  input  1  a nonzero is present on the input stream.
- in_ready  output  1  the issuer accepts the nonzero this cycle.
- in_v0  input  64  matrix value, IEEE double.
- in_v1  input  64  vector value, IEEE double.
- in_row_end  input  1  this nonzero is the last one of its row.
- in_last  input  1  this nonzero is the last one of the matrix; it implies in_row_end.
- row_retired  input  1  one pulse per completed row, driven by mac push_out; returns one credit.
- wr  output  1  mac write strobe.
- row  output  LOG2_INTERMEDIATOR_DEPTH  row tag for the write.
- v0  output  64  registered copy of in_v0.
- v1  output  64  registered copy of in_v1.
- eof  output  1  one-cycle flush pulse to mac.
- done  output  1  level; all rows of the pass have retired.
- credit_err  output  1  sticky; a credit was returned while the counter was already full.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; row tag=0; credits=INTERMEDIATOR_DEPTH; row_open=0.
  - wr=0, row=0, v0=0, v1=0, eof=0, done=0, credit_err=0, in_ready=0.
  - Reset mid-pass abandons everything; credits are not reconciled.
- FSM states: IDLE, RUN, FLUSH, WAIT, DONE.
  - IDLE: in_ready=0. start moves to RUN and clears done.
  - RUN: in_ready = !(~row_open && credits==0). The transfer is in_valid && in_ready.
  - RUN: accepting a nonzero with in_last moves to FLUSH.
  - FLUSH: lasts one cycle with in_ready=0, then moves to WAIT.
  - WAIT: when credits==INTERMEDIATOR_DEPTH, move to DONE.
  - DONE: done=1. start moves to RUN, clears done, and keeps the tag counter, which is not reset between passes.
- Issue path: one register stage. An accepted nonzero at cycle N gives wr=1 at N+1, with row equal to the tag in use at acceptance and v0/v1 equal to the accepted values. wr=0 otherwise; row/v0/v1 hold their values.
- eof: asserted on the cycle after the wr carrying the in_last nonzero, i.e. acceptance of in_last plus 2. It is always strictly after the last wr.
- Row tagging:
  - The first accepted nonzero of a row (row_open=0) consumes one credit and sets row_open.
  - Accepting a nonzero with in_row_end clears row_open and advances the tag.
  - Tag wraps from INTERMEDIATOR_DEPTH-1 to 0 explicitly, which is correct for non-power-of-2 depths.
  - A single-nonzero row both opens and closes in the same accept.
- Credits:
  - Width is LOG2_INTERMEDIATOR_DEPTH+1 bits.
  - Consume and row_retired in the same cycle gives a net change of 0.
  - row_retired with credits==DEPTH and no consume: credits stay put and credit_err is set.
  - row_retired is counted in every state except reset.
- Stall: in RUN with credits==0 and no open row, in_ready=0. A row_retired that cycle does not raise in_ready until the next cycle; in_ready is combinational from registered state only.
- in_valid outside RUN is ignored and no data is consumed.

Decomposition:
- common.vh (shared, already included by the mac datapath): log2 function; FSM state localparams IDLE/RUN/FLUSH/WAIT/DONE.
- One natural sub-module, mac_credit_counter: a saturating up/down counter holding consume, return, full, empty and err.
- Tag counter, FSM and output register stay in the top level.

Test Plan:
- Reset: hold rst=0 while driving random inputs → all outputs 0, in_ready=0. Release rst, pulse start → in_ready=1 next cycle.
- Basic issue, three rows of sizes 2, 1, 3 with in_last on the sixth nonzero:
  - wr row tags are 0,0,1,2,2,2, each one cycle after its accept.
  - eof pulses exactly once, one cycle after the sixth wr.
  - done stays 0 until 3 row_retired pulses have arrived, then rises.
- Credit stall with DEPTH=4: issue 4 single-nonzero rows without retiring any → the 5th nonzero sees in_ready=0. Pulse row_retired once → in_ready=1 on the following cycle and the 5th issues with tag 0 (wrap).
- Simultaneous consume and return: open a new row in the same cycle as a row_retired at credits=1 → credits remain 1 and no stall occurs.
- Overflow: pulse row_retired in IDLE with full credits → credit_err=1 and stays 1 until reset; credits remain DEPTH.
- Mid-pass reset: assert rst during RUN with 2 rows open → everything returns to reset values immediately, no eof is emitted, and a new pass starts again at tag 0.

Source files
------------

// File: rtl/mac_row_issuer_pkg.sv
// Shared types and helpers for the mac row issuer: FSM state encoding,
// datapath width and the tag-width helper used for parameter defaults.
package mac_row_issuer_pkg;

  localparam int DATA_W = 64;

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    FLUSH,
    WAIT,
    DONE
  } state_t;

  // Number of bits needed to hold value (minimum 1).
  function automatic int log2(input int value);
    int n;
    n = 1;
    for (int i = 0; i < 31; i++) begin
      if ((value >> i) != 0) n = i + 1;
    end
    return n;
  endfunction

endpackage

// File: rtl/mac_row_issuer_credit_counter.sv
// Credit counter bounding open intermediator rows: consume on row open,
// return on mac push-out, sticky error on a return while already full.
module mac_credit_counter #(
  parameter int DEPTH = 1024,
  parameter int CNT_W = 11
) (
  input  logic clk,
  input  logic rst,
  input  logic consume,
  input  logic ret,
  output logic full,
  output logic empty,
  output logic err
);

  logic [CNT_W-1:0] credits;

  assign full  = (credits == CNT_W'(DEPTH));
  assign empty = (credits == '0);

  // A simultaneous consume and return cancel out.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      credits <= CNT_W'(DEPTH);
      err     <= 1'b0;
    end else if (consume && !ret && !empty) begin
      credits <= credits - 1'b1;
    end else if (ret && !consume) begin
      if (full) err <= 1'b1;
      else      credits <= credits + 1'b1;
    end
  end

endmodule

// File: rtl/mac_row_issuer.sv
// Issues one registered mac write per accepted nonzero with a wrapping row
// tag, throttles open rows by credits, and sequences the eof flush and done.
module mac_row_issuer
  import mac_row_issuer_pkg::*;
#(
  parameter int INTERMEDIATOR_DEPTH      = 1024,
  parameter int LOG2_INTERMEDIATOR_DEPTH = log2(INTERMEDIATOR_DEPTH - 1)
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                start,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [DATA_W-1:0]                   in_v0,
  input  logic [DATA_W-1:0]                   in_v1,
  input  logic                                in_row_end,
  input  logic                                in_last,
  input  logic                                row_retired,
  output logic                                wr,
  output logic [LOG2_INTERMEDIATOR_DEPTH-1:0] row,
  output logic [DATA_W-1:0]                   v0,
  output logic [DATA_W-1:0]                   v1,
  output logic                                eof,
  output logic                                done,
  output logic                                credit_err
);

  localparam int TAG_W = LOG2_INTERMEDIATOR_DEPTH;
  localparam logic [TAG_W-1:0] TAG_LAST = TAG_W'(INTERMEDIATOR_DEPTH - 1);

  state_t             state, state_nx;
  logic [TAG_W-1:0]   tag;
  logic               row_open;
  logic               accept, consume, full, empty;
  logic               wr_p1, last_p1, eof_p2;
  logic [TAG_W-1:0]   row_p1;
  logic [DATA_W-1:0]  v0_p1, v1_p1;

  // Ready depends only on registered state, never on same-cycle returns.
  assign in_ready = (state == RUN) && (row_open || !empty);
  assign accept   = in_valid && in_ready;
  assign consume  = accept && !row_open;

  mac_credit_counter #(
    .DEPTH(INTERMEDIATOR_DEPTH),
    .CNT_W(TAG_W + 1)
  ) u_credits (
    .clk    (clk),
    .rst    (rst),
    .consume(consume),
    .ret    (row_retired),
    .full   (full),
    .empty  (empty),
    .err    (credit_err)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (accept && in_last) state_nx = FLUSH;
      FLUSH:   state_nx = WAIT;
      WAIT:    if (full) state_nx = DONE;
      DONE:    if (start) state_nx = RUN;
      default: state_nx = IDLE;
    endcase
  end

  assign done = (state == DONE);

  // Tag persists across passes; explicit wrap keeps non-power-of-2 depths correct.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tag      <= '0;
      row_open <= 1'b0;
    end else if (accept) begin
      if (in_row_end || in_last) begin
        row_open <= 1'b0;
        tag      <= (tag == TAG_LAST) ? '0 : tag + 1'b1;
      end else begin
        row_open <= 1'b1;
      end
    end
  end

  // Stage p1: registered mac write; stage p2: eof one cycle behind the last write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_p1   <= 1'b0;
      last_p1 <= 1'b0;
      eof_p2  <= 1'b0;
      row_p1  <= '0;
      v0_p1   <= '0;
      v1_p1   <= '0;
    end else begin
      wr_p1   <= accept;
      last_p1 <= accept && in_last;
      eof_p2  <= last_p1;
      if (accept) begin
        row_p1 <= tag;
        v0_p1  <= in_v0;
        v1_p1  <= in_v1;
      end
    end
  end

  assign wr  = wr_p1;
  assign row = row_p1;
  assign v0  = v0_p1;
  assign v1  = v1_p1;
  assign eof = eof_p2;

endmodule

// File: tb/tb_mac_row_issuer.sv
// Directed and randomized bench for mac_row_issuer (depth 4) against a
// cycle-level behavioural model of rows, credits and pass sequencing.
module tb_mac_row_issuer;

  localparam int D = 4;
  localparam int S_IDLE = 0, S_RUN = 1, S_FLUSH = 2, S_WAIT = 3, S_DONE = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, in_valid, in_ready, in_row_end, in_last, row_retired;
  logic [63:0] in_v0, in_v1, v0, v1;
  logic        wr, eof, done, credit_err;
  logic [1:0]  row;

  mac_row_issuer #(.INTERMEDIATOR_DEPTH(D)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_v0(in_v0), .in_v1(in_v1), .in_row_end(in_row_end), .in_last(in_last),
    .row_retired(row_retired), .wr(wr), .row(row), .v0(v0), .v1(v1),
    .eof(eof), .done(done), .credit_err(credit_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fails  = 0;

  // model state
  int          m_state, m_tag, m_cred, eof_cnt;
  bit          m_open, m_err, eof_pend, exp_wr, exp_eof;
  logic [63:0] exp_row, exp_v0, exp_v1;
  int          wr_rows[$];
  bit          acc;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    m_state = S_IDLE; m_tag = 0; m_cred = D; m_open = 0; m_err = 0;
    eof_pend = 0; exp_wr = 0; exp_eof = 0; exp_row = 0; exp_v0 = 0; exp_v1 = 0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_wr"}, wr, 0);
    chk({tag, "_row"}, row, 0);
    chk({tag, "_v0"}, v0, 0);
    chk({tag, "_v1"}, v1, 0);
    chk({tag, "_eof"}, eof, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err"}, credit_err, 0);
    chk({tag, "_rdy"}, in_ready, 0);
  endtask

  // One clock cycle, called at a negedge; returns whether the nonzero was accepted.
  task automatic cyc(input bit v, input logic [63:0] a, input logic [63:0] b,
                     input bit re, input bit la, input bit rt, input bit st,
                     output bit accepted);
    bit rdy;
    int dc;
    in_valid = v; in_v0 = a; in_v1 = b; in_row_end = re | la; in_last = la;
    row_retired = rt; start = st;
    #1;
    rdy = (m_state == S_RUN) && !(!m_open && m_cred == 0);
    chk("in_ready", in_ready, rdy);
    accepted = v && rdy;
    exp_eof  = eof_pend;
    eof_pend = accepted && la;
    exp_wr   = accepted;
    if (accepted) begin exp_row = m_tag; exp_v0 = a; exp_v1 = b; end
    dc = (accepted && !m_open) ? -1 : 0;
    if (rt) begin
      if (m_cred == D && dc == 0) m_err = 1;
      else dc += 1;
    end
    case (m_state)
      S_IDLE:  if (st) m_state = S_RUN;
      S_RUN:   if (accepted && la) m_state = S_FLUSH;
      S_FLUSH: m_state = S_WAIT;
      S_WAIT:  if (m_cred == D) m_state = S_DONE;
      default: if (st) m_state = S_RUN;
    endcase
    m_cred += dc;
    if (accepted) begin
      if (re || la) begin m_open = 0; m_tag = (m_tag + 1) % D; end
      else m_open = 1;
    end
    @(posedge clk); #1;
    chk("wr", wr, exp_wr);
    chk("row", row, exp_row);
    chk("v0", v0, exp_v0);
    chk("v1", v1, exp_v1);
    chk("eof", eof, exp_eof);
    chk("done", done, m_state == S_DONE);
    chk("credit_err", credit_err, m_err);
    if (wr) wr_rows.push_back(int'(row));
    if (eof) eof_cnt++;
    @(negedge clk);
  endtask

  task automatic idle(input bit rt);
    cyc(0, 64'h0, 64'h0, 0, 0, rt, 0, acc);
  endtask

  task automatic nz(input bit re, input bit la, input bit rt);
    cyc(1, {$urandom, $urandom}, {$urandom, $urandom}, re, la, rt, 0, acc);
  endtask

  task automatic do_reset(input string tag);
    #2 rst = 1'b0;
    #1 chk_all_zero(tag);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
  endtask

  // Retire every outstanding row and wait for done, bounded.
  task automatic drain(input string tag);
    for (int i = 0; i < 40 && m_state != S_DONE; i++) idle(m_cred < D);
    chk(tag, done, 1);
  endtask

  initial begin
    rst = 1'b0; start = 0; in_valid = 0; in_v0 = 0; in_v1 = 0;
    in_row_end = 0; in_last = 0; row_retired = 0;
    model_reset();

    // Reset held with random inputs
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      start = 1'($urandom); in_valid = 1'($urandom); row_retired = 1'($urandom);
      in_row_end = 1'($urandom); in_last = 1'($urandom);
      in_v0 = {$urandom, $urandom}; in_v1 = {$urandom, $urandom};
      @(posedge clk); #1;
      chk_all_zero("reset");
    end
    @(negedge clk);
    rst = 1'b1; start = 0; in_valid = 0; row_retired = 0; in_last = 0; in_row_end = 0;

    // Basic pass: rows of size 2, 1, 3
    cyc(0, 0, 0, 0, 0, 0, 1, acc);
    chk("started_ready", in_ready, 1);
    wr_rows.delete(); eof_cnt = 0;
    nz(0, 0, 0); nz(1, 0, 0); nz(1, 0, 0);
    nz(0, 0, 0); nz(0, 0, 0); nz(1, 1, 0);
    for (int i = 0; i < 4; i++) idle(0);
    chk("basic_done_early", done, 0);
    idle(1); idle(0); idle(1); idle(1); idle(0); idle(0);
    chk("basic_done", done, 1);
    chk("basic_eof_count", eof_cnt, 1);
    chk("basic_wr_count", wr_rows.size(), 6);
    begin
      int exp_tags[6] = '{0, 0, 1, 2, 2, 2};
      for (int i = 0; i < 6 && i < wr_rows.size(); i++)
        chk("basic_tag", wr_rows[i], exp_tags[i]);
    end

    // Randomized pass starting from DONE
    cyc(0, 0, 0, 0, 0, 0, 1, acc);
    eof_cnt = 0;
    for (int i = 0; i < 150; i++)
      cyc($urandom_range(3) != 0, {$urandom, $urandom}, {$urandom, $urandom},
          $urandom_range(2) == 0, 0, ($urandom_range(2) == 0) && (m_cred < D), 0, acc);
    acc = 0;
    for (int i = 0; i < 40 && !acc; i++) nz(1, 1, m_cred == 0);
    chk("rand_last_accepted", acc, 1);
    drain("rand_done");
    chk("rand_eof_count", eof_cnt, 1);

    // Credit stall and wrap
    do_reset("reset_b");
    cyc(0, 0, 0, 0, 0, 0, 1, acc);
    for (int i = 0; i < 4; i++) nz(1, 0, 0);
    nz(1, 0, 0); nz(1, 0, 0);
    chk("stall_no_accept", acc, 0);
    nz(1, 0, 1);
    chk("stall_ret_same_cycle", acc, 0);
    nz(1, 0, 0);
    chk("stall_released", acc, 1);
    chk("wrap_tag", row, 0);

    // Simultaneous consume and return at one credit
    idle(1);
    nz(0, 0, 1);
    chk("simul_accept", acc, 1);
    nz(1, 0, 0);
    nz(1, 0, 0);
    chk("simul_no_stall", acc, 1);
    acc = 0;
    for (int i = 0; i < 20 && !acc; i++) nz(1, 1, m_cred == 0);
    drain("stall_done");

    // Overflow in IDLE
    do_reset("reset_c");
    idle(1);
    chk("overflow_err", credit_err, 1);
    idle(0); idle(0);
    chk("overflow_sticky", credit_err, 1);
    cyc(0, 0, 0, 0, 0, 0, 1, acc);
    chk("overflow_full_ready", in_ready, 1);

    // Mid-pass reset with two rows open
    nz(1, 0, 0); nz(0, 0, 0);
    do_reset("midpass");
    eof_cnt = 0;
    for (int i = 0; i < 3; i++) idle(0);
    chk("midpass_no_eof", eof_cnt, 0);
    cyc(0, 0, 0, 0, 0, 0, 1, acc);
    nz(1, 0, 0);
    chk("restart_tag", row, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
